hilo_muldiv: RTL

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv_if.sv | 24 ++
 rtl/hilo_muldiv.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - issue/move/result bundle between pipeline and HI/LO unit
interface hilo_muldiv_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
    output hi_o, lo_o, busy_o, done_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO
module hilo_muldiv (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic [31:0] a_q, a_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        signed_in, signed_q, quo_neg, rem_neg, div_ge;
  logic [31:0] mag_rs, mag_rt, div_sub;
  logic [32:0] mul_sum;

  assign signed_in = ~bus.op_i[0];
  assign mag_rs    = (signed_in && bus.rs_i[31]) ? -bus.rs_i : bus.rs_i;
  assign mag_rt    = (signed_in && bus.rt_i[31]) ? -bus.rt_i : bus.rt_i;

  // Multiply: p holds {partial product, remaining multiplier bits}.
  assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
  // Divide: p holds {partial remainder, dividend bits being shifted out / quotient shifted in}.
  assign div_ge    = p_q[63:31] >= {1'b0, a_q};
  assign div_sub   = p_q[62:31] - a_q;

  assign signed_q  = ~op_q[0];
  assign quo_neg   = signed_q & (rs_q[31] ^ rt_q[31]);
  assign rem_neg   = signed_q & rs_q[31];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    a_d     = a_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d   = bus.op_i;
          rs_d   = bus.rs_i;
          rt_d   = bus.rt_i;
          cnt_d  = 5'd0;
          busy_d = 1'b1;
          if (bus.op_i[1]) begin
            state_d = S_DIV;
            p_d     = {32'd0, mag_rs};
            a_d     = mag_rt;
          end else begin
            state_d = S_MUL;
            p_d     = {32'd0, mag_rt};
            a_d     = mag_rs;
          end
        end else begin
          if (bus.mthi_i) hi_d = bus.wdata_i;
          if (bus.mtlo_i) lo_d = bus.wdata_i;
        end
      end
      S_MUL: begin
        p_d   = {mul_sum, p_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        p_d   = div_ge ? {div_sub, p_q[30:0], 1'b1} : {p_q[62:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        // Counter wrapped to 0 on entry: first cycle fixes signs, second commits.
        if (cnt_q == 5'd0) begin
          cnt_d = 5'd1;
          if (!op_q[1]) begin
            if (quo_neg) p_d = -p_q;
          end else if (rt_q == 32'd0) begin
            p_d = {rs_q, 32'hFFFF_FFFF};
          end else begin
            p_d = {rem_neg ? -p_q[63:32] : p_q[63:32],
                   quo_neg ? -p_q[31:0]  : p_q[31:0]};
          end
        end else begin
          hi_d    = p_q[63:32];
          lo_d    = p_q[31:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      a_q     <= 32'd0;
      p_q     <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule
